// File: rtl/display_scan.sv
// display_scan: converts each 16-bit word leaving the buffer to decimal with a
// sequential double-dabble converter (one bit per clock) and drives an 8-digit
// multiplexed, active-low 7-segment display. Digit 7 shows the producer ID,
// digit 5 the slow-clock programming value, digits 4..0 the converted value.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for data_valid
// S_SHIFT  | 16 adjust-and-shift steps, one input bit per clock
// S_COMMIT | copy BCD result to the display; chain straight into the next word

module display_scan #(
  parameter int REFRESH_COUNT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [15:0] data,
  input  logic [2:0]  prog,
  input  logic [1:0]  modulo,
  output logic [7:0]  an,
  output logic [7:0]  dec_ddp,
  output logic        busy
);

  localparam int RW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_load;
  logic [15:0] w_load_data;
  logic        w_clr_pend;
  logic        w_capture;

  logic [15:0] r_shift;
  logic [19:0] r_bcd;
  logic [19:0] w_bcd_adj;
  logic [3:0]  r_bitcnt;
  logic        r_pend_valid;
  logic [15:0] r_pend_data;
  logic [19:0] r_disp;

  logic [RW-1:0] r_refresh;
  logic [2:0]    r_idx;
  logic [7:0]    w_seg;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h03;
      4'd1:    s = 8'h9F;
      4'd2:    s = 8'h25;
      4'd3:    s = 8'h0D;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h49;
      4'd6:    s = 8'h41;
      4'd7:    s = 8'h1F;
      4'd8:    s = 8'h01;
      4'd9:    s = 8'h09;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign busy = (r_state != S_IDLE);

  // A word arriving mid-conversion parks in the one-deep pending slot; in
  // COMMIT it is taken directly so no idle cycle separates conversions.
  assign w_capture = data_valid && (r_state == S_SHIFT);

  // Converter state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Converter next-state and load control; newest word wins in COMMIT
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_data = data;
    w_clr_pend  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (data_valid) begin
          w_next = S_SHIFT;
          w_load = 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_bitcnt == 4'd15) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        if (data_valid) begin
          w_next     = S_SHIFT;
          w_load     = 1'b1;
          w_clr_pend = 1'b1;
        end else if (r_pend_valid) begin
          w_next      = S_SHIFT;
          w_load      = 1'b1;
          w_load_data = r_pend_data;
          w_clr_pend  = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Add 3 to every BCD nibble that is 5 or more before the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Double-dabble datapath and display register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift  <= '0;
      r_bcd    <= '0;
      r_bitcnt <= '0;
      r_disp   <= '0;
    end else begin
      if (w_load) begin
        r_shift  <= w_load_data;
        r_bcd    <= '0;
        r_bitcnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_bcd    <= (w_bcd_adj << 1) | {19'd0, r_shift[15]};
        r_shift  <= {r_shift[14:0], 1'b0};
        r_bitcnt <= r_bitcnt + 4'd1;
      end
      if (r_state == S_COMMIT) r_disp <= r_bcd;
    end
  end

  // Pending word slot, latest arrival overwrites
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
    end else if (w_clr_pend) begin
      r_pend_valid <= 1'b0;
    end else if (w_capture) begin
      r_pend_valid <= 1'b1;
      r_pend_data  <= data;
    end
  end

  // Refresh counter and digit index
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_refresh <= '0;
      r_idx     <= '0;
    end else if (r_refresh == RW'(REFRESH_COUNT - 1)) begin
      r_refresh <= '0;
      r_idx     <= r_idx + 3'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // Segment pattern for the selected digit, leading zeros blanked on 4..1
  always_comb begin
    w_seg = 8'hFF;
    case (r_idx)
      3'd0: w_seg = seg7(r_disp[3:0]);
      3'd1: w_seg = (r_disp[19:4]  == '0) ? 8'hFF : seg7(r_disp[7:4]);
      3'd2: w_seg = (r_disp[19:8]  == '0) ? 8'hFF : seg7(r_disp[11:8]);
      3'd3: w_seg = (r_disp[19:12] == '0) ? 8'hFF : seg7(r_disp[15:12]);
      3'd4: w_seg = (r_disp[19:16] == '0) ? 8'hFF : seg7(r_disp[19:16]);
      3'd5: w_seg = seg7({1'b0, prog});
      3'd6: w_seg = 8'hFF;
      3'd7: begin
        case (modulo)
          2'd1:    w_seg = 8'h71;
          2'd2:    w_seg = 8'hE1;
          default: w_seg = 8'hFF;
        endcase
      end
      default: w_seg = 8'hFF;
    endcase
  end

  // Registered display outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      an      <= 8'hFF;
      dec_ddp <= 8'hFF;
    end else begin
      an      <= ~(8'h01 << r_idx);
      dec_ddp <= w_seg;
    end
  end

endmodule
